encoder42_evt: RTL and testbench

ENCODER42_EVT -- requirements
Module: encoder42_evt

---
 rtl/encoder42_evt_pkg.sv | 30 +++
 rtl/encoder42_evt_sync.sv | 41 ++++
 rtl/encoder42_evt.sv | 112 +++++++++++
 tb/tb_encoder42_evt.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder42_evt_pkg.sv
// Shared types and constants for the event-driven 4:2 encoder.
// Contents: FSM state enum, per-line code constants, default synchronizer
// depth, and the combinational priority-select helper.
package encoder42_evt_pkg;

    localparam int unsigned N_LINES         = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Two-bit codes presented on {A,B}; pending bit index equals the code.
    localparam logic [1:0] CODE_W = 2'b11;
    localparam logic [1:0] CODE_X = 2'b10;
    localparam logic [1:0] CODE_Y = 2'b01;
    localparam logic [1:0] CODE_Z = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Lowest set index wins (code 0 highest priority); returns 0 when empty.
    function automatic logic [1:0] prio_code(input logic [N_LINES-1:0] p);
        logic [1:0] code;
        code = 2'b00;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (p[i]) code = 2'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/encoder42_evt_sync.sv
// Per-line synchronizer and falling-edge detector.
// Ports: clk, rst_n; req_n async active-low request;
//        evt_c one-cycle pulse on a synchronized 1->0 transition.
module evt_sync
    import encoder42_evt_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_n,
    output logic evt_c
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] seen_q, seen_d;
    logic                   prev_q, prev_d;

    // seen_q tracks which sync stages hold a real post-reset sample, so the
    // reset value of 1 can never masquerade as a "before" level. A line held
    // low through reset therefore produces no event after release.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_n};
        seen_d = {seen_q[SYNC_STAGES-2:0], 1'b1};
        prev_d = seen_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1];
        evt_c  = prev_q & ~sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            seen_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            seen_q <= seen_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/encoder42_evt.sv
// Event-driven 4:2 priority encoder with valid/ready handshake.
// Ports: clk, rst_n; w_n/x_n/y_n/z_n async requests (codes 3/2/1/0);
//        A,B presented code; valid/ready handshake; ovr sticky overrun,
//        ovr_clr synchronous clear.
module encoder42_evt
    import encoder42_evt_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic w_n,
    input  logic x_n,
    input  logic y_n,
    input  logic z_n,
    output logic A,
    output logic B,
    output logic valid,
    input  logic ready,
    output logic ovr,
    input  logic ovr_clr
);

    logic [N_LINES-1:0] req_n;
    logic [N_LINES-1:0] evt_c;

    assign req_n = {w_n, x_n, y_n, z_n};

    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        evt_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .req_n (req_n[i]),
            .evt_c (evt_c[i])
        );
    end

    state_e             state_q, state_d;
    logic [1:0]         code_q, code_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic [N_LINES-1:0] pend_q, pend_d;
    logic [N_LINES-1:0] clr_c;
    logic [N_LINES-1:0] kept_c;
    logic               xfer_c;

    // Next-state: pending bookkeeping, overrun detection, FSM.
    always_comb begin
        xfer_c  = valid_q & ready;
        clr_c   = xfer_c ? (N_LINES'(1) << code_q) : '0;
        kept_c  = pend_q & ~clr_c;
        // A new event on the line being cleared re-sets its bit (set wins).
        pend_d  = kept_c | evt_c;

        ovr_d   = ovr_q;
        if (ovr_clr)                ovr_d = 1'b0;
        if (|(evt_c & kept_c))      ovr_d = 1'b1;

        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = HOLD;
                    code_d  = prio_code(pend_q);
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                // Code is frozen until the consumer takes it.
                if (xfer_c) begin
                    if (|pend_d) begin
                        code_d = prio_code(pend_d);
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= CODE_Z;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
        end
    end

    assign A     = code_q[1];
    assign B     = code_q[0];
    assign valid = valid_q;
    assign ovr   = ovr_q;

endmodule

// File: tb/tb_encoder42_evt.sv
// Self-checking bench for encoder42_evt: expected codes are queued when
// stimulus is applied; a monitor queues observed transfers for comparison.
module tb_encoder42_evt;

    logic       clk;
    logic       rst_n;
    logic [3:0] lines_n;   // {w_n, x_n, y_n, z_n}
    logic       A, B, valid, ready, ovr, ovr_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    encoder42_evt #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_n     (lines_n[3]),
        .x_n     (lines_n[2]),
        .y_n     (lines_n[1]),
        .z_n     (lines_n[0]),
        .A       (A),
        .B       (B),
        .valid   (valid),
        .ready   (ready),
        .ovr     (ovr),
        .ovr_clr (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change only just after posedge, so a negedge sample of
    // valid&&ready predicts the transfer at the next posedge.
    always @(negedge clk) begin
        if (rst_n && valid && ready) obs_q.push_back({A, B});
    end

    // Decoder24 model: code c drives line index c low.
    function automatic logic [3:0] dec24(input logic [1:0] c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int c;
        c = 0;
        while (obs_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lines_n = 4'hF; ready = 1'b0; ovr_clr = 1'b0;
        tick(2);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if ({A, B} !== 2'b00) begin n_fail++; $display("FAIL reset_code: got %b want 00", {A, B}); end
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", ovr); end
        rst_n = 1'b1;
        tick(6);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", valid); end
    endtask

    task automatic test_single();
        logic [1:0] got, e;
        ready = 1'b1;
        lines_n[1] = 1'b0;          // sampled low at edge k
        exp_q.push_back(2'b01);
        tick(3);                    // after edge k+2
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_early: valid %b at k+2, want 0", valid); end
        tick(1);                    // after edge k+3
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: valid %b at k+3, want 1", valid); end
        n_checks++; if ({A, B} !== 2'b01) begin n_fail++; $display("FAIL single_code: got %b want 01", {A, B}); end
        tick(1);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: valid %b at k+4, want 0", valid); end
        tick(1);
        lines_n[1] = 1'b1;
        wait_obs(exp_q.size(), 40);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL single_xfer: no transfer observed, want %b", e); end
            else begin got = obs_q.pop_front(); if (got !== e) begin n_fail++; $display("FAIL single_xfer: got %b want %b", got, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL single_extra: %0d extra transfers, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] got, e;
        ready = 1'b1;
        lines_n = 4'b0010;          // w, x, z fall together
        exp_q.push_back(2'b00); exp_q.push_back(2'b10); exp_q.push_back(2'b11);
        tick(4);                    // after edge k+3
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid_cont: cycle %0d valid %b want 1", i, valid); end
            tick(1);
        end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL simul_valid_end: got %b want 0", valid); end
        lines_n = 4'hF;
        wait_obs(exp_q.size(), 40);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL simul_xfer: no transfer observed, want %b", e); end
            else begin got = obs_q.pop_front(); if (got !== e) begin n_fail++; $display("FAIL simul_xfer: got %b want %b", got, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL simul_extra: %0d extra transfers, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_backpressure();
        logic [1:0] got, e;
        ready = 1'b0;
        lines_n[2] = 1'b0;
        tick(2);
        lines_n[0] = 1'b0;
        tick(8);
        n_checks++; if (valid !== 1'b1 || {A, B} !== 2'b10) begin n_fail++; $display("FAIL bp_hold: valid %b code %b want 1/10", valid, {A, B}); end
        tick(3);
        n_checks++; if ({A, B} !== 2'b10) begin n_fail++; $display("FAIL bp_stable: code %b want 10", {A, B}); end
        exp_q.push_back(2'b10); exp_q.push_back(2'b00);
        ready = 1'b1;
        lines_n = 4'hF;
        wait_obs(exp_q.size(), 40);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL bp_xfer: no transfer observed, want %b", e); end
            else begin got = obs_q.pop_front(); if (got !== e) begin n_fail++; $display("FAIL bp_xfer: got %b want %b", got, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bp_extra: %0d extra transfers, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_overrun();
        logic [1:0] got, e;
        ready = 1'b0;
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %b want 0", ovr); end
        lines_n[1] = 1'b0; tick(2); lines_n[1] = 1'b1; tick(3);
        lines_n[1] = 1'b0; tick(2); lines_n[1] = 1'b1; tick(6);
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", ovr); end
        n_checks++; if (valid !== 1'b1 || {A, B} !== 2'b01) begin n_fail++; $display("FAIL ovr_present: valid %b code %b want 1/01", valid, {A, B}); end
        exp_q.push_back(2'b01);
        ready = 1'b1;
        wait_obs(exp_q.size(), 40);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL ovr_xfer: no transfer observed, want %b", e); end
            else begin got = obs_q.pop_front(); if (got !== e) begin n_fail++; $display("FAIL ovr_xfer: got %b want %b", got, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ovr_extra: %0d extra transfers, want 0", obs_q.size()); obs_q.delete(); end
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
        ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0; tick(1);
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ovr); end
    endtask

    task automatic test_reset_mid_hold();
        logic [1:0] got, e;
        // Leave ovr set so reset has something to clear.
        ready = 1'b0;
        lines_n[0] = 1'b0; tick(2); lines_n[0] = 1'b1; tick(3);
        lines_n[0] = 1'b0; tick(2); lines_n[0] = 1'b1; tick(6);
        exp_q.push_back(2'b00);
        ready = 1'b1;
        wait_obs(exp_q.size(), 40);
        ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL rst_pre_xfer: no transfer observed, want %b", e); end
            else begin got = obs_q.pop_front(); if (got !== e) begin n_fail++; $display("FAIL rst_pre_xfer: got %b want %b", got, e); end end
        end
        lines_n = 4'b1001;          // x and y fall together, held low
        tick(6);
        n_checks++; if (valid !== 1'b1 || {A, B} !== 2'b01 || ovr !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_hold: valid %b code %b ovr %b want 1/01/1", valid, {A, B}, ovr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0 || {A, B} !== 2'b00 || ovr !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: valid %b code %b ovr %b want 0/00/0", valid, {A, B}, ovr);
        end
        tick(2);
        rst_n = 1'b1;
        ready = 1'b1;
        tick(15);
        n_checks++; if (obs_q.size() != 0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_evt: transfers %0d valid %b want 0/0", obs_q.size(), valid); obs_q.delete();
        end
        lines_n = 4'hF;
        tick(6);
    endtask

    task automatic test_round_trip();
        logic [1:0] got, e;
        logic [1:0] seq[4];
        seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b11; seq[3] = 2'b01;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lines_n = dec24(seq[i]);
            exp_q.push_back(seq[i]);
            tick(3);
            lines_n = 4'hF;
            tick(4);
        end
        wait_obs(exp_q.size(), 40);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL roundtrip_xfer: no transfer observed, want %b", e); end
            else begin got = obs_q.pop_front(); if (got !== e) begin n_fail++; $display("FAIL roundtrip_xfer: got %b want %b", got, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL roundtrip_extra: %0d extra transfers, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_overrun();
        test_reset_mid_hold();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
